store_module: RTL and testbench

- Store-side counterpart of the load ECC path.
- Accepts a store from the pipeline and SECDED-encodes 32 data bits into 7 parity bits.
- Writes data plus parity to the data cache.
- Partial (byte-enabled) stores run a read-modify-write: read the word, check and correct it, merge the new bytes, re-encode, then write.
- Sits between the memory stage and the data cache, beside load_module.

---
 rtl/store_ecc_pkg.sv | 28 ++
 rtl/correction_detection.sv | 53 +++++
 rtl/secded_encode.sv | 28 ++
 rtl/store_module.sv | 184 ++++++++++++++++++
 tb/tb_store_module.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_ecc_pkg.sv
// Shared FSM state type and SECDED codeword layout for the store ECC path.
package store_ecc_pkg;

    localparam int DATA_W = 32;
    localparam int PAR_W  = 7;
    localparam int CW_LEN = 38;
    localparam int CHK_N  = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_MERGE,
        S_WR_REQ,
        S_DONE
    } state_e;

    // Codeword positions of the check bits parity[0..5].
    localparam logic [5:0] CHECK_POS [CHK_N] = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32};

    // Data bit k lives at the k-th non-power-of-two position.
    localparam logic [5:0] DATA_POS [DATA_W] = '{
        6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
        6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
        6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
        6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
    };

endpackage

// File: rtl/correction_detection.sv
// Combinational SECDED checker: corrects one flipped bit, flags two flipped bits.
module correction_detection
    import store_ecc_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    input  logic [PAR_W-1:0]  parity_i,
    output logic [DATA_W-1:0] data_o,
    output logic              single_err_o,
    output logic              double_err_o
);

    logic [CW_LEN:1] cw;
    logic [CHK_N-1:0] syn;
    logic             overall;

    always_comb begin
        cw = '0;
        for (int d = 0; d < DATA_W; d++) begin
            cw[DATA_POS[d]] = data_i[d];
        end
        for (int i = 0; i < CHK_N; i++) begin
            cw[CHECK_POS[i]] = parity_i[i];
        end
        syn = '0;
        for (int i = 0; i < CHK_N; i++) begin
            for (int p = 1; p <= CW_LEN; p++) begin
                if (p[i]) begin
                    syn[i] = syn[i] ^ cw[p];
                end
            end
        end
        overall      = (^data_i) ^ (^parity_i);
        data_o       = data_i;
        single_err_o = 1'b0;
        double_err_o = 1'b0;
        if (overall) begin
            // Odd overall parity with a syndrome outside the codeword cannot be a single flip.
            if (syn <= 6'd38) begin
                single_err_o = 1'b1;
                for (int d = 0; d < DATA_W; d++) begin
                    if (syn == DATA_POS[d]) begin
                        data_o[d] = ~data_i[d];
                    end
                end
            end else begin
                double_err_o = 1'b1;
            end
        end else if (syn != '0) begin
            double_err_o = 1'b1;
        end
    end

endmodule

// File: rtl/secded_encode.sv
// Combinational SECDED encoder: 32 data bits to 6 Hamming check bits plus overall parity.
module secded_encode
    import store_ecc_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [PAR_W-1:0]  parity_o
);

    logic [CW_LEN:1] cw;

    always_comb begin
        cw = '0;
        for (int d = 0; d < DATA_W; d++) begin
            cw[DATA_POS[d]] = data_i[d];
        end
        parity_o = '0;
        for (int i = 0; i < CHK_N; i++) begin
            for (int p = 1; p <= CW_LEN; p++) begin
                if (p[i]) begin
                    parity_o[i] = parity_o[i] ^ cw[p];
                end
            end
        end
        // Overall bit makes the full 38-position word even.
        parity_o[PAR_W-1] = (^data_i) ^ (^parity_o[CHK_N-1:0]);
    end

endmodule

// File: rtl/store_module.sv
// Store path to the data cache: SECDED-encodes full-word stores, read-modify-writes partial ones.
// Optional saturating single-error counter on port err_count when STORE_ECC_ERRCNT_EN is defined.
module store_module
    import store_ecc_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              store_valid,
    output logic              store_ready,
    input  logic [ADDR_W-1:0] store_addr,
    input  logic [31:0]       store_data,
    input  logic [3:0]        store_be,
    output logic              store_done,
    output logic              cache_rd_req,
    output logic [ADDR_W-1:0] cache_addr,
    input  logic              cache_rd_valid,
    input  logic [31:0]       data_Cache,
    input  logic [6:0]        parity_Cache,
    output logic              cache_wr_req,
    output logic [31:0]       cache_wr_data,
    output logic [6:0]        cache_wr_parity,
    input  logic              cache_wr_ack,
    output logic              single_error,
    output logic              DED_exception
`ifdef STORE_ECC_ERRCNT_EN
    ,output logic [15:0]      err_count
`endif
);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [3:0]          be_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [PAR_W-1:0]    wr_par_q;
    logic                ready_q;
    logic                rd_req_q;
    logic                wr_req_q;
    logic                done_q;
    logic                sngl_q;
    logic                ded_q;

    logic [DATA_W-1:0]   merge_d;
    logic [DATA_W-1:0]   enc_in_d;
    logic [PAR_W-1:0]    enc_par_d;
    logic [DATA_W-1:0]   cd_data_d;
    logic                cd_single_d;
    logic                cd_double_d;
    logic                rd_take_d;

    always_comb begin
        merge_d = rd_data_q;
        for (int b = 0; b < 4; b++) begin
            if (be_q[b]) begin
                merge_d[8*b +: 8] = data_q[8*b +: 8];
            end
        end
    end

    // The single encoder serves the full-word path in IDLE and the merged word otherwise.
    assign enc_in_d  = (state_q == S_IDLE) ? store_data : merge_d;
    assign rd_take_d = (state_q == S_RD_REQ) && cache_rd_valid;

    secded_encode u_enc (
        .data_i   (enc_in_d),
        .parity_o (enc_par_d)
    );

    correction_detection u_cd (
        .data_i       (data_Cache),
        .parity_i     (parity_Cache),
        .data_o       (cd_data_d),
        .single_err_o (cd_single_d),
        .double_err_o (cd_double_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            rd_data_q <= '0;
            wr_data_q <= '0;
            wr_par_q  <= '0;
            ready_q   <= 1'b1;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            done_q    <= 1'b0;
            sngl_q    <= 1'b0;
            ded_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            sngl_q <= 1'b0;
            ded_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (store_valid && ready_q) begin
                        addr_q  <= store_addr;
                        data_q  <= store_data;
                        be_q    <= store_be;
                        ready_q <= 1'b0;
                        if (store_be == 4'hF) begin
                            wr_data_q <= store_data;
                            wr_par_q  <= enc_par_d;
                            wr_req_q  <= 1'b1;
                            state_q   <= S_WR_REQ;
                        end else if (store_be == 4'h0) begin
                            state_q <= S_DONE;
                        end else begin
                            rd_req_q <= 1'b1;
                            state_q  <= S_RD_REQ;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (rd_take_d) begin
                        rd_req_q  <= 1'b0;
                        rd_data_q <= cd_data_d;
                        if (cd_double_d) begin
                            ded_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            sngl_q  <= cd_single_d;
                            state_q <= S_MERGE;
                        end
                    end
                end
                S_MERGE: begin
                    wr_data_q <= merge_d;
                    wr_par_q  <= enc_par_d;
                    wr_req_q  <= 1'b1;
                    state_q   <= S_WR_REQ;
                end
                S_WR_REQ: begin
                    if (cache_wr_ack) begin
                        wr_req_q <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    rd_req_q <= 1'b0;
                    wr_req_q <= 1'b0;
                    ready_q  <= 1'b1;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

`ifdef STORE_ECC_ERRCNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (rd_take_d && cd_single_d && !cd_double_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif

    assign store_ready     = ready_q;
    assign store_done      = done_q;
    assign cache_rd_req    = rd_req_q;
    assign cache_addr      = addr_q;
    assign cache_wr_req    = wr_req_q;
    assign cache_wr_data   = wr_data_q;
    assign cache_wr_parity = wr_par_q;
    assign single_error    = sngl_q;
    assign DED_exception   = ded_q;

endmodule

// File: tb/tb_store_module.sv
// Self-checking bench for store_module: directed and random stores against a cache responder and scoreboard.
`timescale 1ns/1ps
module tb_store_module;
  import store_ecc_pkg::*;

  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [6:0]  par;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              store_valid;
  logic              store_ready;
  logic [ADDR_W-1:0] store_addr;
  logic [31:0]       store_data;
  logic [3:0]        store_be;
  logic              store_done;
  logic              cache_rd_req;
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_rd_valid;
  logic [31:0]       data_Cache;
  logic [6:0]        parity_Cache;
  logic              cache_wr_req;
  logic [31:0]       cache_wr_data;
  logic [6:0]        cache_wr_parity;
  logic              cache_wr_ack;
  logic              single_error;
  logic              DED_exception;
`ifdef STORE_ECC_ERRCNT_EN
  logic [15:0]       err_count;
`endif

  store_module #(.ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .store_valid     (store_valid),
    .store_ready     (store_ready),
    .store_addr      (store_addr),
    .store_data      (store_data),
    .store_be        (store_be),
    .store_done      (store_done),
    .cache_rd_req    (cache_rd_req),
    .cache_addr      (cache_addr),
    .cache_rd_valid  (cache_rd_valid),
    .data_Cache      (data_Cache),
    .parity_Cache    (parity_Cache),
    .cache_wr_req    (cache_wr_req),
    .cache_wr_data   (cache_wr_data),
    .cache_wr_parity (cache_wr_parity),
    .cache_wr_ack    (cache_wr_ack),
    .single_error    (single_error),
    .DED_exception   (DED_exception)
`ifdef STORE_ECC_ERRCNT_EN
    ,.err_count      (err_count)
`endif
  );

  logic [31:0] ref_data;
  logic [6:0]  ref_par;

  secded_encode u_ref (
    .data_i   (ref_data),
    .parity_o (ref_par)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Independent encoder: check bits are the XOR of positions holding a 1.
  function automatic logic [6:0] tb_encode(input logic [31:0] d);
    logic [5:0] acc;
    int k;
    acc = '0;
    k   = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (d[k]) acc = acc ^ pos[5:0];
        k++;
      end
    end
    return {(^d) ^ (^acc), acc};
  endfunction

  // ---------------- scoreboard / cache responder ----------------
  wr_t exp_q[$];
  int  exp_lat_q[$];
  int  acc_cyc  = 0;
  int  n_done   = 0;
  int  n_sngl   = 0;
  int  n_ded    = 0;
  int  n_rd     = 0;
  int  rd_left  = 0;
  int  wr_left  = 0;
  bit  wr_allow = 1'b1;
  bit  spurious_ack = 1'b0;

  always @(negedge clk) begin
    wr_t e;
    int  lat;
    logic ack;
    if (!reset) begin
      if (store_valid && store_ready) acc_cyc = cyc;
      if (single_error) n_sngl++;
      if (DED_exception) n_ded++;
      if (store_done) begin
        n_done++;
        if (exp_lat_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          lat = exp_lat_q.pop_front();
          chk("done_latency", cyc - acc_cyc, lat);
        end
      end
    end
    cache_rd_valid = 1'b0;
    if (cache_rd_req) begin
      if (rd_left == 0) begin
        cache_rd_valid = 1'b1;
        n_rd++;
      end else begin
        rd_left--;
      end
    end
    ack = spurious_ack;
    if (cache_wr_req && wr_allow) begin
      if (wr_left == 0) begin
        ack = 1'b1;
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", cache_addr, e.addr);
          chk("wr_data", cache_wr_data, e.data);
          chk("wr_parity", cache_wr_parity, e.par);
        end
      end else begin
        wr_left--;
      end
    end
    cache_wr_ack = ack;
  end

  // ---------------- driver ----------------
  int exp_sngl = 0;
  int exp_ded  = 0;
  int exp_rd   = 0;

  // flip indices: -1 none, 0..31 data bit, 32..38 parity bit (idx-32)
  task automatic do_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] mem, input int fa, input int fb,
                          input int rw, input int ww);
    logic [31:0] rd_d;
    logic [6:0]  rd_p;
    logic [31:0] merged;
    int          nflip;
    int          d0;
    int          t;
    wr_t         e;
    rd_d  = mem;
    rd_p  = tb_encode(mem);
    nflip = 0;
    if (fa >= 0) begin
      nflip++;
      if (fa < 32) rd_d[fa] = ~rd_d[fa]; else rd_p[fa-32] = ~rd_p[fa-32];
    end
    if (fb >= 0) begin
      nflip++;
      if (fb < 32) rd_d[fb] = ~rd_d[fb]; else rd_p[fb-32] = ~rd_p[fb-32];
    end
    if (be == 4'hF) begin
      e.addr = addr; e.data = wdata; e.par = tb_encode(wdata);
      exp_q.push_back(e);
      exp_lat_q.push_back(3 + ww);
    end else if (be == 4'h0) begin
      exp_lat_q.push_back(2);
    end else begin
      exp_rd++;
      if (nflip == 2) begin
        exp_ded++;
        exp_lat_q.push_back(3 + rw);
      end else begin
        if (nflip == 1) exp_sngl++;
        for (int b = 0; b < 4; b++) merged[8*b +: 8] = be[b] ? wdata[8*b +: 8] : mem[8*b +: 8];
        e.addr = addr; e.data = merged; e.par = tb_encode(merged);
        exp_q.push_back(e);
        exp_lat_q.push_back(5 + rw + ww);
      end
    end
    data_Cache   = rd_d;
    parity_Cache = rd_p;
    rd_left      = rw;
    wr_left      = ww;
    t = 0;
    while (!store_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!store_ready) chk("ready_timeout", 0, 1);
    d0          = n_done;
    store_addr  = addr;
    store_data  = wdata;
    store_be    = be;
    store_valid = 1'b1;
    @(posedge clk); #1;
    store_valid = 1'b0;
    t = 0;
    while (n_done == d0 && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    chk("done_seen", n_done - d0, 1);
    chk("wr_pending", exp_q.size(), 0);
    chk("single_count", n_sngl, exp_sngl);
    chk("ded_count", n_ded, exp_ded);
    chk("rd_count", n_rd, exp_rd);
`ifdef STORE_ECC_ERRCNT_EN
    chk("err_count", err_count, exp_sngl);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int mode;
    int fa;
    int fb;
    int d0;
    reset          = 1'b1;
    store_valid    = 1'b0;
    store_addr     = '0;
    store_data     = '0;
    store_be       = '0;
    data_Cache     = '0;
    parity_Cache   = '0;
    cache_rd_valid = 1'b0;
    cache_wr_ack   = 1'b0;
    ref_data       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", store_ready, 1);
    chk("rst_rd_req", cache_rd_req, 0);
    chk("rst_wr_req", cache_wr_req, 0);
    chk("rst_done", store_done, 0);
    chk("rst_addr", cache_addr, 0);
    chk("rst_wr_data", cache_wr_data, 0);
    chk("rst_wr_par", cache_wr_parity, 0);
    chk("rst_pulses", {single_error, DED_exception}, 0);
`ifdef STORE_ECC_ERRCNT_EN
    chk("rst_err_count", err_count, 0);
`endif
    reset = 1'b0;

    chk("enc_zero", tb_encode(32'h0), 7'h00);
    chk("enc_one", tb_encode(32'h1), 7'h43);
    ref_data = 32'h0000_0001; #1;
    chk("ref_one", ref_par, 7'h43);
    ref_data = 32'h1122_3344; #1;
    chk("ref_vs_model", ref_par, tb_encode(32'h1122_3344));
    ref_data = 32'hFFFF_FFFF; #1;
    chk("ref_vs_model_ones", ref_par, tb_encode(32'hFFFF_FFFF));
    @(posedge clk); #1;

    do_store(32'h0000_0010, 32'h0000_0000, 4'hF, 32'h0, -1, -1, 0, 0);
    do_store(32'h0000_0014, 32'h0000_0001, 4'hF, 32'h0, -1, -1, 0, 0);
    do_store(32'h0000_0020, 32'h0000_00AA, 4'b0001, 32'h1122_3344, -1, -1, 0, 0);
    do_store(32'h0000_0024, 32'h0000_00AA, 4'b0001, 32'h1122_3344, 9, -1, 0, 0);
    do_store(32'h0000_0028, 32'h0000_00AA, 4'b0001, 32'h1122_3344, 9, 20, 0, 0);
    do_store(32'h0000_002C, 32'hDEAD_BEEF, 4'h0, 32'h1122_3344, -1, -1, 0, 0);
    do_store(32'h0000_0030, 32'hCAFE_0000, 4'b1100, 32'h0BAD_F00D, 38, -1, 2, 3);

    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 2);
      fa = -1;
      fb = -1;
      if (mode >= 1) fa = $urandom_range(0, 38);
      if (mode == 2) begin
        fb = $urandom_range(0, 38);
        if (fb == fa) fb = (fa + 1) % 39;
      end
      do_store($urandom, $urandom, 4'($urandom_range(0, 15)), $urandom, fa, fb,
               $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Abort in WR_REQ with the ack withheld, then offer stray acks.
    wr_allow = 1'b0;
    d0 = n_done;
    store_addr  = 32'h0000_0040;
    store_data  = 32'h1234_5678;
    store_be    = 4'hF;
    store_valid = 1'b1;
    @(posedge clk); #1;
    store_valid = 1'b0;
    chk("abort_wr_req_up", cache_wr_req, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_wr_req", cache_wr_req, 0);
    chk("abort_ready", store_ready, 1);
    wr_allow     = 1'b1;
    spurious_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    spurious_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_write", cache_wr_req, 0);
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_ready_after", store_ready, 1);
`ifdef STORE_ECC_ERRCNT_EN
    chk("abort_err_count", err_count, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
